dram_loader: RTL and testbench
==============================

Name: dram_loader

Overview:
- Write side of the 512x15 dispatch RAM (DRAM) that the IR board only reads.
- Takes diagnostic load functions from the EBUS and stages address, A/B and J fields, then commits one DRAM word.
- Generates the odd-parity bit on commit, and supports read-back with parity check so diagnostics can load and verify the DRAM before microcode runs.
- Sits between CTL diag decode and the DRAM write port (wea/dina/addra).

Parameters:
- DRAM_WIDTH, 15, stored word width: A[0:2], B[0:2], P, J[1:4], J[7:10].
- DRAM_SIZE, 512, number of words.
- DRAM_ADDR_BITS, 9, equals $clog2(DRAM_SIZE).
- RD_LATENCY, 1, cycles from address to dout on the synchronous RAM.

Ports:
- clk  in  1  EBOX clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- diag_load  in  1  one-cycle strobe: diag load function valid.
- diag_func  in  3  function code [4:6].
- ebus_data  in  36  EBUS data [0:35], sampled on diag_load.
- dram_addr  out  9  DRAM address.
- dram_din  out  15  write data.
- dram_we  out  1  write enable, one-cycle pulse.
- dram_dout  in  15  read data from DRAM.
- busy  out  1  commit or read-back in progress.
- rd_data  out  15  last read-back word.
- par_err  out  1  sticky: read-back word had even parity.
- ovr  out  1  sticky: diag_load arrived while busy.

Behaviour:
- Reset: all outputs 0; staging registers 0; FSM IDLE.
- Word packing (MSB-first, index 0 = MSB): din[0:2]=A, [3:5]=B, [6]=P, [7:10]=J1:4, [11:14]=J7:10.
- Parity rule: P is chosen so XOR over all 15 bits = 1 (odd).
- Functions, accepted only in IDLE; each sample uses the ebus_data bits listed:
  - 0 LDADR: addr <= ebus_data[27:35].
  - 1 LDAB: A <= [30:32], B <= [33:35].
  - 2 LDJH: J1:4 <= [32:35].
  - 3 LDJL: J7:10 <= [32:35].
  - 4 WRITE: P computed; goes to WR.
  - 5 WRITEP: P <= ebus_data[35] raw, no parity generation; goes to WR. Used to inject bad parity.
  - 6 READ: goes to RD.
  - 7 CLR: clear par_err, ovr, all staging and rd_data.
- FSM:
  - IDLE.
  - WR: dram_we=1 for exactly one cycle, busy=1, then IDLE.
  - RD: busy=1, hold addr for RD_LATENCY cycles; on the last cycle capture rd_data <= dram_dout, and set par_err if ^dram_dout==0; then IDLE.
- Latency: WRITE occupies 1 busy cycle; READ occupies RD_LATENCY+1. busy rises the cycle after the strobe.
- diag_load while busy: function ignored, ovr<=1, state unaffected.
- dram_din is driven continuously from staging; dram_addr is held constant through WR/RD.
- Async reset mid-WR: dram_we drops immediately; no partial state is retained.
- par_err stays set until CLR or reset; a later good read does not clear it.
- Simultaneous CLR and parity-error capture cannot occur (CLR is ignored while busy).

Optional Feature:
- DRAM_LOADER_AUTOINC_EN defined: addr increments by 1 at the end of every WR; 511 wraps to 0. READ does not increment.
- Undefined: addr changes only via LDADR.

Decomposition:
- Shared package (ebox_pkg): DRAM_WIDTH, DRAM_SIZE, DRAM_ADDR_BITS, field bit-position constants, a diag function code enum, and a packed dram_word_t struct {A,B,P,JH,JL}. The same package is used by ir and dram_loader so the packing cannot diverge.
- One sub-module: dram_parity (combinational 14-bit in -> P out, plus a 15-bit odd check). Shared with ir's DRAM_ODD_PARITY.

Test Plan:
- LDADR 0o254, LDAB A=3 B=5, LDJH 0xA, LDJL 0x3, WRITE -> dram_we exactly 1 cycle, dram_addr=0o254, din = 011 101 P 1010 0011 with P making odd parity.
- Same address, READ with RAM model returning the written word -> rd_data matches after RD_LATENCY+1 cycles, par_err=0.
- WRITEP with ebus_data[35] inverted, then READ -> par_err=1; a subsequent good READ leaves par_err=1; CLR clears it.
- WRITE followed by diag_load LDADR on the next cycle (busy) -> ovr=1, addr unchanged.
- AUTOINC_EN: LDADR 511, WRITE, WRITE -> second write at addr 0. Without the macro: both writes at 511.
- Assert rst_n low during WR -> dram_we, busy and addr go to 0 immediately; after release, IDLE accepts LDADR.

Source files
------------

// File: rtl/ebox_pkg.sv
// Shared EBOX dispatch-RAM definitions: word packing, field
// positions and diag function codes, used by ir and dram_loader.
package ebox_pkg;

  localparam int DRAM_WIDTH     = 15;
  localparam int DRAM_SIZE      = 512;
  localparam int DRAM_ADDR_BITS = $clog2(DRAM_SIZE);
  localparam int RD_LATENCY     = 1;
  localparam int EBUS_WIDTH     = 36;

  // DRAM word LSB positions (word bit 0 = MSB = vector bit 14)
  localparam int DW_A_LSB  = 12;
  localparam int DW_B_LSB  = 9;
  localparam int DW_P_BIT  = 8;
  localparam int DW_JH_LSB = 4;
  localparam int DW_JL_LSB = 0;

  // EBUS bit k (MSB-first) lives at vector bit 35-k
  localparam int EB_ADDR_LSB = 0;
  localparam int EB_A_LSB    = 3;
  localparam int EB_B_LSB    = 0;
  localparam int EB_J_LSB    = 0;
  localparam int EB_P_BIT    = 0;

  typedef enum logic [2:0] {
    FN_LDADR  = 3'd0,
    FN_LDAB   = 3'd1,
    FN_LDJH   = 3'd2,
    FN_LDJL   = 3'd3,
    FN_WRITE  = 3'd4,
    FN_WRITEP = 3'd5,
    FN_READ   = 3'd6,
    FN_CLR    = 3'd7
  } diag_func_e;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       p;
    logic [3:0] jh;
    logic [3:0] jl;
  } dram_word_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } dl_state_e;

  function automatic logic [13:0] dram_payload(
    input dram_word_t w
  );
    return {w.a, w.b, w.jh, w.jl};
  endfunction

endpackage

// File: rtl/dram_parity.sv
// DRAM odd parity: generate P over the 14 data bits,
// and check a full 15-bit word for odd parity.
module dram_parity
  import ebox_pkg::*;
(
  input  logic [DRAM_WIDTH-2:0] payload,
  input  logic [DRAM_WIDTH-1:0] word,
  output logic                  p,
  output logic                  odd_ok
);

  // P makes the XOR over all 15 bits equal 1
  assign p      = ~^payload;
  assign odd_ok = ^word;

endmodule

// File: rtl/dram_loader.sv
// DRAM write side: stages diag loads, commits/reads back one word.
// Build option: DRAM_LOADER_AUTOINC_EN (addr +1 after each write).
module dram_loader
  import ebox_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      diag_load,
  input  logic [2:0]                diag_func,
  input  logic [EBUS_WIDTH-1:0]     ebus_data,
  output logic [DRAM_ADDR_BITS-1:0] dram_addr,
  output logic [DRAM_WIDTH-1:0]     dram_din,
  output logic                      dram_we,
  input  logic [DRAM_WIDTH-1:0]     dram_dout,
  output logic                      busy,
  output logic [DRAM_WIDTH-1:0]     rd_data,
  output logic                      par_err,
  output logic                      ovr
);

  localparam int RD_CNT_W = $clog2(RD_LATENCY + 1);
  localparam logic [RD_CNT_W-1:0] RD_LAST =
    RD_CNT_W'(RD_LATENCY);

  dl_state_e                 state_q;
  dl_state_e                 state_d;
  logic [RD_CNT_W-1:0]       rd_cnt_q;
  logic [DRAM_ADDR_BITS-1:0] addr_q;
  dram_word_t                word_q;
  logic [DRAM_WIDTH-1:0]     rd_data_q;
  logic                      par_err_q;
  logic                      ovr_q;

  diag_func_e func;
  logic       accept;
  logic       rd_last;
  logic       gen_p;
  logic       rd_odd;
  logic       unused_ebus;

  assign func   = diag_func_e'(diag_func);
  assign accept = diag_load && (state_q == S_IDLE);
  assign unused_ebus = ^ebus_data[EBUS_WIDTH-1:DRAM_ADDR_BITS];

  dram_parity u_par (
    .payload (dram_payload(word_q)),
    .word    (dram_dout),
    .p       (gen_p),
    .odd_ok  (rd_odd)
  );

  // State register and read-latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_RD && !rd_last)
        rd_cnt_q <= rd_cnt_q + 1'b1;
      else
        rd_cnt_q <= '0;
    end
  end

  // Next state and strobes
  always_comb begin
    state_d = state_q;
    dram_we = 1'b0;
    busy    = 1'b0;
    rd_last = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (diag_load) begin
          unique case (1'b1)
            func == FN_WRITE,
            func == FN_WRITEP: state_d = S_WR;
            func == FN_READ:   state_d = S_RD;
            default:           state_d = S_IDLE;
          endcase
        end
      end
      S_WR: begin
        dram_we = 1'b1;
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      S_RD: begin
        busy = 1'b1;
        if (rd_cnt_q == RD_LAST) begin
          rd_last = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Staging registers: address and word fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      word_q <= '0;
    end else if (accept) begin
      unique case (func)
        FN_LDADR:
          addr_q <= ebus_data[EB_ADDR_LSB +: DRAM_ADDR_BITS];
        FN_LDAB: begin
          word_q.a <= ebus_data[EB_A_LSB +: 3];
          word_q.b <= ebus_data[EB_B_LSB +: 3];
        end
        FN_LDJH:   word_q.jh <= ebus_data[EB_J_LSB +: 4];
        FN_LDJL:   word_q.jl <= ebus_data[EB_J_LSB +: 4];
        FN_WRITE:  word_q.p  <= gen_p;
        FN_WRITEP: word_q.p  <= ebus_data[EB_P_BIT];
        FN_READ:   ;
        FN_CLR: begin
          addr_q <= '0;
          word_q <= '0;
        end
      endcase
    end
`ifdef DRAM_LOADER_AUTOINC_EN
    else if (state_q == S_WR) begin
      addr_q <= addr_q + 1'b1;
    end
`endif
  end

  // Read-back capture and sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      par_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (diag_load && state_q != S_IDLE)
        ovr_q <= 1'b1;
      if (rd_last) begin
        rd_data_q <= dram_dout;
        if (!rd_odd)
          par_err_q <= 1'b1;
      end
      if (accept && func == FN_CLR) begin
        rd_data_q <= '0;
        par_err_q <= 1'b0;
        ovr_q     <= 1'b0;
      end
    end
  end

  assign dram_addr = addr_q;
  assign dram_din  = word_q;
  assign rd_data   = rd_data_q;
  assign par_err   = par_err_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_dram_loader.sv
// Self-checking bench for dram_loader with a RAM model and
// a field-level reference of the staging/commit rules.
module tb_dram_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        diag_load = 1'b0;
  logic [2:0]  diag_func = 3'd0;
  logic [35:0] ebus_data = '0;
  logic [8:0]  dram_addr;
  logic [14:0] dram_din;
  logic        dram_we;
  logic [14:0] dram_dout;
  logic        busy;
  logic [14:0] rd_data;
  logic        par_err;
  logic        ovr;

  int vecs = 0;
  int errs = 0;

  logic [14:0] ram [512];

  logic [8:0]  m_addr;
  logic [2:0]  m_a, m_b;
  logic        m_p;
  logic [3:0]  m_jh, m_jl;
  logic [14:0] m_mem [512];
  logic [14:0] m_rd;
  logic        m_perr, m_ovr;

  dram_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .diag_load (diag_load),
    .diag_func (diag_func),
    .ebus_data (ebus_data),
    .dram_addr (dram_addr),
    .dram_din  (dram_din),
    .dram_we   (dram_we),
    .dram_dout (dram_dout),
    .busy      (busy),
    .rd_data   (rd_data),
    .par_err   (par_err),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dram_we) ram[dram_addr] <= dram_din;
    dram_dout <= ram[dram_addr];
  end

  task automatic chk(input string tag,
                     input logic [35:0] got,
                     input logic [35:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] m_word();
    return {m_a, m_b, m_p, m_jh, m_jl};
  endfunction

  function automatic logic odd_fill(input logic [13:0] v);
    return ($countones(v) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic m_clear();
    m_addr = '0; m_a = '0; m_b = '0; m_p = 1'b0;
    m_jh = '0; m_jl = '0; m_rd = '0;
    m_perr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic issue(input logic [2:0] f,
                       input logic [35:0] d);
    @(negedge clk);
    diag_func = f;
    ebus_data = d;
    diag_load = 1'b1;
    @(negedge clk);
    diag_load = 1'b0;
  endtask

  task automatic m_after_write();
    m_mem[m_addr] = m_word();
`ifdef DRAM_LOADER_AUTOINC_EN
    m_addr = m_addr + 9'd1;
`endif
  endtask

  task automatic do_op(input logic [2:0] f,
                       input logic [35:0] d);
    case (f)
      3'd0: m_addr = d[8:0];
      3'd1: begin m_a = d[5:3]; m_b = d[2:0]; end
      3'd2: m_jh = d[3:0];
      3'd3: m_jl = d[3:0];
      3'd4: m_p = odd_fill({m_a, m_b, m_jh, m_jl});
      3'd5: m_p = d[0];
      3'd7: begin
        m_clear();
      end
      default: ;
    endcase
    issue(f, d);
    if (f == 3'd4 || f == 3'd5) begin
      chk("wr_we", 36'(dram_we), 36'd1);
      chk("wr_busy", 36'(busy), 36'd1);
      chk("wr_addr", 36'(dram_addr), 36'(m_addr));
      chk("wr_din", 36'(dram_din), 36'(m_word()));
      @(negedge clk);
      chk("wr_we_off", 36'(dram_we), 36'd0);
      chk("wr_busy_off", 36'(busy), 36'd0);
      m_after_write();
      chk("wr_addr_end", 36'(dram_addr), 36'(m_addr));
    end else if (f == 3'd6) begin
      chk("rd_busy0", 36'(busy), 36'd1);
      chk("rd_we", 36'(dram_we), 36'd0);
      @(negedge clk);
      chk("rd_busy1", 36'(busy), 36'd1);
      @(negedge clk);
      chk("rd_busy_off", 36'(busy), 36'd0);
      m_rd = m_mem[m_addr];
      if ($countones(m_rd) % 2 == 0) m_perr = 1'b1;
      chk("rd_data", 36'(rd_data), 36'(m_rd));
      chk("rd_addr", 36'(dram_addr), 36'(m_addr));
    end else begin
      chk("ld_busy", 36'(busy), 36'd0);
      chk("ld_addr", 36'(dram_addr), 36'(m_addr));
      chk("ld_din", 36'(dram_din), 36'(m_word()));
      chk("ld_rd", 36'(rd_data), 36'(m_rd));
    end
    chk("par_err", 36'(par_err), 36'(m_perr));
    chk("ovr", 36'(ovr), 36'(m_ovr));
  endtask

  initial begin
    logic [2:0]  f;
    logic [35:0] d;
    logic        bad_p;
    logic [8:0]  wr2_addr;
    for (int i = 0; i < 512; i++) begin
      ram[i] = '0;
      m_mem[i] = '0;
    end
    m_clear();

    #12;
    chk("rst_we", 36'(dram_we), 36'd0);
    chk("rst_busy", 36'(busy), 36'd0);
    chk("rst_addr", 36'(dram_addr), 36'd0);
    chk("rst_din", 36'(dram_din), 36'd0);
    chk("rst_status", 36'({rd_data, par_err, ovr}), 36'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // packed write of a known word
    do_op(3'd0, 36'o254);
    do_op(3'd1, 36'o35);
    do_op(3'd2, 36'hA);
    do_op(3'd3, 36'h3);
    issue(3'd4, 36'd0);
    chk("plan_din", 36'(dram_din), 36'(15'b011_101_1_1010_0011));
    chk("plan_addr", 36'(dram_addr), 36'o254);
    m_p = 1'b1;
    @(negedge clk);
    chk("plan_we_once", 36'(dram_we), 36'd0);
    m_after_write();

    // read back the same word
    do_op(3'd0, 36'o254);
    do_op(3'd6, 36'd0);
    chk("plan_rd", 36'(rd_data), 36'(15'b011_101_1_1010_0011));

    // inject bad parity, read, good read, clear
    bad_p = ~odd_fill({m_a, m_b, m_jh, m_jl});
    do_op(3'd5, 36'(bad_p));
    do_op(3'd0, 36'o254);
    do_op(3'd6, 36'd0);
    chk("inj_perr", 36'(par_err), 36'd1);
    do_op(3'd4, 36'd0);
    do_op(3'd0, 36'o254);
    do_op(3'd6, 36'd0);
    chk("perr_sticky", 36'(par_err), 36'd1);
    do_op(3'd7, 36'd0);
    chk("clr_perr", 36'(par_err), 36'd0);

    // load while busy
    do_op(3'd0, 36'o100);
    @(negedge clk);
    diag_func = 3'd4;
    diag_load = 1'b1;
    m_p = odd_fill({m_a, m_b, m_jh, m_jl});
    @(negedge clk);
    diag_func = 3'd0;
    ebus_data = 36'o7;
    @(negedge clk);
    diag_load = 1'b0;
    m_after_write();
    m_ovr = 1'b1;
    chk("ovr_set", 36'(ovr), 36'd1);
    chk("ovr_addr", 36'(dram_addr), 36'(m_addr));
    chk("ovr_busy", 36'(busy), 36'd0);

    // address wrap / hold at top
    do_op(3'd0, 36'd511);
    do_op(3'd4, 36'd0);
    @(negedge clk);
    wr2_addr = dram_addr;
    do_op(3'd4, 36'd0);
`ifdef DRAM_LOADER_AUTOINC_EN
    chk("wr2_addr", 36'(wr2_addr), 36'd0);
`else
    chk("wr2_addr", 36'(wr2_addr), 36'd511);
`endif

    // reset during a write
    do_op(3'd0, 36'o17);
    issue(3'd4, 36'd0);
    chk("pre_rst_we", 36'(dram_we), 36'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we", 36'(dram_we), 36'd0);
    chk("arst_busy", 36'(busy), 36'd0);
    chk("arst_addr", 36'(dram_addr), 36'd0);
    chk("arst_ovr", 36'(ovr), 36'd0);
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd0, 36'o5);
    chk("post_rst_addr", 36'(dram_addr), 36'o5);

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      f = 3'($urandom_range(0, 7));
      if (f == 3'd7 && $urandom_range(0, 3) != 0)
        f = 3'd6;
      d = {4'($urandom), 32'($urandom)};
      if (f == 3'd0)
        d[8:0] = ($urandom_range(0, 9) == 0) ?
                 9'd511 : 9'($urandom_range(0, 15));
      do_op(f, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
